// File: rtl/riscv_pipe_pkg.sv
// ============================================================================
// Package     : riscv_pipe_pkg
// Description : Shared definitions for the RISC-V datapath pipeline stages.
//               Holds the skid-stage state encoding, the occupancy width and
//               a helper that decodes a state into its entry count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pipe_pkg;

  localparam int OCC_W = 2;

  typedef logic [1:0] skid_state_t;

  // Skid stage state encoding.
  localparam skid_state_t ST_EMPTY = 2'd0;  // no entries held
  localparam skid_state_t ST_BUSY  = 2'd1;  // main register valid
  localparam skid_state_t ST_FULL  = 2'd2;  // main and skid registers valid

  // Number of entries held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(input skid_state_t st);
    case (st)
      ST_BUSY: occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage : riscv_pipe_pkg

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module      : pipe_skid_stage
// Description : Back-pressured WIDTH-bit pipeline register slice with a
//               one-entry skid buffer and a synchronous flush.
//               Every output comes straight from a flop, so in_ready never
//               depends combinationally on out_ready.
// Ports       : clk        - clock, rising edge
//               reset      - synchronous active-high reset
//               flush      - synchronous squash of all held entries
//               in_valid   - upstream payload valid
//               in_ready   - stage can accept a payload (registered)
//               in_data    - upstream payload
//               out_valid  - out_data valid (registered)
//               out_ready  - downstream accepts this cycle
//               out_data   - head payload (main register)
//               occupancy  - number of held entries, 0..2 (registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage
  import riscv_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [OCC_W-1:0] occ_q;

  logic             w_in_fire;
  logic             w_out_fire;

  // The registered status flags mirror the current state, so they are the
  // same values a decode of state_q would give, but come directly from flops.
  assign w_in_fire  = in_valid  & in_ready_q;
  assign w_out_fire = out_valid_q & out_ready;

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (w_in_fire) begin
          main_d  = in_data;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          // Head leaves and the new payload takes its place: no bubble.
          main_d = in_data;
        end else if (w_in_fire) begin
          // Downstream stalled: absorb the payload into the skid register.
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (w_out_fire) begin
          state_d = ST_EMPTY;
        end
      end

      ST_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (w_out_fire) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush squashes everything held, including a payload accepted this
    // cycle; a concurrent out_fire has already completed downstream.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  // --------------------------------------------------------------------------
  // State, storage and registered status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_FULL);
      occ_q       <= occ_of(state_d);
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule : pipe_skid_stage

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Self-checking bench for pipe_skid_stage. A queue holds the
//               payloads the stage should contain in acceptance order; the
//               expected outputs are derived from that queue each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model: held payloads (front = head) and the value the main
  // register shows (retained after drain, zeroed by reset/flush).
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_main;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate the handshake from the model's pre-edge contents,
  // advance across the edge, then compare every output #1 after it.
  task automatic step(input string tag);
    int  n;
    bit  m_in_fire, m_out_fire;
    n          = mq.size();
    m_in_fire  = in_valid  && (n < 2);
    m_out_fire = out_ready && (n > 0);
    @(posedge clk);
    if (reset || flush) begin
      mq.delete();
      m_main = '0;
    end else begin
      if (m_out_fire) void'(mq.pop_front());
      if (m_in_fire)  mq.push_back(in_data);
      if (mq.size() > 0) m_main = mq[0];
    end
    #1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    check({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    check({tag, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
    check({tag, ".out_data"},  64'(out_data),  64'(m_main));
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    m_main = '0;
    step("reset");
    step("reset");
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) step("idle");
    check("idle_data", 64'(out_data), 64'h0);

    // Streaming with out_ready high.
    drive(1'b1, 32'h11, 1'b1); step("stream");
    check("stream_first", 64'(out_data), 64'h11);
    drive(1'b1, 32'h22, 1'b1); step("stream");
    drive(1'b1, 32'h33, 1'b1); step("stream");
    drive(1'b1, 32'h44, 1'b1); step("stream");
    check("stream_last", 64'(out_data), 64'h44);
    check("stream_occ", 64'(occupancy), 64'd1);
    drive(1'b0, '0, 1'b1); step("drain");

    // Stall: A0, A1 absorbed, A2 held upstream.
    drive(1'b1, 32'hA0, 1'b0); step("stall");
    drive(1'b1, 32'hA1, 1'b0); step("stall");
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_occ", 64'(occupancy), 64'd2);
    drive(1'b1, 32'hA2, 1'b0); step("stall");
    step("stall");
    check("stall_hold", 64'(out_data), 64'hA0);
    drive(1'b1, 32'hA2, 1'b1); step("release");
    check("release_A1", 64'(out_data), 64'hA1);
    step("release");
    check("release_A2", 64'(out_data), 64'hA2);
    drive(1'b0, '0, 1'b1); step("release");

    // Flush while FULL with an offered payload.
    drive(1'b1, 32'hB0, 1'b0); step("fill");
    drive(1'b1, 32'hB1, 1'b0); step("fill");
    flush = 1'b1;
    drive(1'b1, 32'hFF, 1'b0); step("flush");
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_data", 64'(out_data), 64'h0);
    drive(1'b0, '0, 1'b1); step("post_flush");
    check("post_flush_valid", 64'(out_valid), 64'd0);

    // Simultaneous fire in BUSY.
    drive(1'b1, 32'h05, 1'b0); step("sim_fire");
    drive(1'b1, 32'h06, 1'b1); step("sim_fire");
    check("sim_fire_data", 64'(out_data), 64'h06);
    check("sim_fire_occ", 64'(occupancy), 64'd1);
    drive(1'b0, '0, 1'b1); step("sim_fire");

    // Reset while FULL, then accept 0x77 immediately.
    drive(1'b1, 32'hC0, 1'b0); step("pre_reset");
    drive(1'b1, 32'hC1, 1'b0); step("pre_reset");
    reset = 1'b1;
    drive(1'b1, 32'hC2, 1'b1); step("mid_reset");
    reset = 1'b0;
    check("mid_reset_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h77, 1'b0); step("post_reset");
    check("post_reset_data", 64'(out_data), 64'h77);
    drive(1'b0, '0, 1'b1); step("post_reset");

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 99) == 0);
      step("rand");
    end
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    step("final");
    step("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_skid_stage

`default_nettype wire
